// File: rtl/lifo_stack_param.sv
`default_nettype none
// ============================================================================
// Module   : lifo_stack_param
// Purpose  : Parametrised synchronous LIFO stack with occupancy count, a
//            combinational peek of the top entry, an almost-full flag,
//            replace-top on simultaneous push+pop, and sticky overflow/
//            underflow error flags.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            enable            - qualifies push/pop
//            push, pop         - operation request ({push,pop})
//            clr_err           - clears the sticky error flags
//            data_in           - data to push / replace with
//            data_out          - registered popped data
//            out_valid         - one-cycle pulse, data_out updated
//            top_data          - current top entry (0 when empty)
//            count             - stored entries, 0..DEPTH
//            empty/full/almost_full - decoded from count
//            invalid           - one-cycle pulse on a rejected operation
//            overflow_err      - sticky, a push was rejected
//            underflow_err     - sticky, a pop was rejected
// Revision : 1.0 - initial release
// ============================================================================
module lifo_stack_param #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              invalid,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int             IDX_W       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_AFULL_CNT = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_out_valid;
    logic              r_invalid;
    logic              r_ovf_err;
    logic              r_unf_err;

    logic              w_empty;
    logic              w_full;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;
    logic              w_replace;
    logic              w_ovf;
    logic              w_unf;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_CNT);

    // Indices are only used when the matching operation is legal, so the
    // truncation never aliases: a push implies count < DEPTH and a read of
    // the top implies count >= 1.
    assign w_wr_idx  = IDX_W'(r_count);
    assign w_top_idx = IDX_W'(r_count - c_ONE);

    assign w_do_push = enable &  push & ~pop & ~w_full;
    assign w_ovf     = enable &  push & ~pop &  w_full;
    assign w_do_pop  = enable & ~push &  pop & ~w_empty;
    assign w_unf     = enable & ~push &  pop &  w_empty;
    assign w_replace = enable &  push &  pop;

    // Storage carries no reset; entries at or above count are never observed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= data_in;
        end else if (w_replace && !w_empty) begin
            r_mem[w_top_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_invalid   <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_unf_err   <= 1'b0;
        end else begin
            r_out_valid <= w_do_pop | w_replace;
            r_invalid   <= w_ovf | w_unf;

            if (w_do_push) begin
                r_count <= r_count + c_ONE;
            end else if (w_do_pop) begin
                r_count <= r_count - c_ONE;
            end

            if (w_do_pop) begin
                r_data_out <= r_mem[w_top_idx];
            end else if (w_replace) begin
                // Replace on an empty stack passes the input straight through.
                r_data_out <= w_empty ? data_in : r_mem[w_top_idx];
            end

            // A new error wins over a coincident clear.
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end else if (clr_err) begin
                r_ovf_err <= 1'b0;
            end

            if (w_unf) begin
                r_unf_err <= 1'b1;
            end else if (clr_err) begin
                r_unf_err <= 1'b0;
            end
        end
    end

    assign data_out      = r_data_out;
    assign out_valid     = r_out_valid;
    assign top_data      = w_empty ? '0 : r_mem[w_top_idx];
    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;
    assign almost_full   = (r_count >= c_AFULL_CNT);
    assign invalid       = r_invalid;
    assign overflow_err  = r_ovf_err;
    assign underflow_err = r_unf_err;

endmodule
`default_nettype wire
